// File: rtl/sonar_pkg.sv
// Shared constants for the sonar range-finder slave.
// Contents: FSM state encodings, register offsets (daddr[3:2]), CTRL bit
// positions, bus drw codes, the saturated/timeout result code and a
// saturating 16-bit increment helper.
package sonar_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_TRIG      = 3'd1;
  localparam state_t ST_WAIT_RISE = 3'd2;
  localparam state_t ST_MEASURE   = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  // Register index as seen on daddr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RESULT = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions (write side: start/auto/irq_en; read side adds status)
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_START   = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_VALID   = 3;
  localparam int CTRL_TIMEOUT = 4;

  localparam logic [1:0] DRW_WRITE = 2'b01;
  localparam logic [1:0] DRW_READ  = 2'b10;

  localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/mod_sonar_if.sv
// Module-bus slot interface shared by all mod_* slaves.
// Signals: ie/de (instruction/data enable), iaddr/daddr (effective
// addresses), drw (00 nop, 01 write, 10 read), din (CPU write data),
// iout/dout (read data returned by the slave).
interface mod_sonar_if;
  logic        ie;
  logic        de;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [1:0]  drw;
  logic [31:0] din;
  logic [31:0] iout;
  logic [31:0] dout;

  modport master (output ie, de, iaddr, daddr, drw, din, input iout, dout);
  modport slave  (input ie, de, iaddr, daddr, drw, din, output iout, dout);
endinterface

// File: rtl/sonar_tick.sv
// Clock divider producing a one-cycle tick_en every DIV clk cycles.
// Ports: clk, rst (sync, active-high), clr (sync restart of the count),
// tick_en (high on the last cycle of each DIV-cycle window).
module sonar_tick #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_en
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Next-count logic: wrap on the last count, restart on clr
  always_comb begin
    tick_en = (cnt_q == W'(DIV - 1));
    if (clr) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Divider count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_sonar.sv
// Ultrasonic range-finder slave for the plpbot module bus.
// Ports: clk, rst (sync, active-high), bus (module-bus slave slot),
// sonar_trig (trigger pulse to sensor), sonar_echo (async echo input),
// i_sonar (one-cycle completion interrupt).
// Registers (daddr[3:2]): 0 CTRL, 1 RESULT (RO), 2 PERIOD, 3 reserved.
module mod_sonar
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES   = 500,
  parameter int TICK_DIV      = 50,
  parameter int TIMEOUT_TICKS = 30000
) (
  input  logic        clk,
  input  logic        rst,
  mod_sonar_if.slave  bus,
  output logic        sonar_trig,
  input  logic        sonar_echo,
  output logic        i_sonar
);

  localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_run_s;
  logic [15:0] width_q, width_d, width_inc_s;
  logic [15:0] result_q, result_d;
  logic [23:0] period_q, period_d;
  logic [23:0] per_cnt_q, per_cnt_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        trig_q, trig_d;
  logic        irq_q, irq_d;
  logic        echo_meta_q, echo_meta_d;
  logic        echo_sync_q, echo_sync_d;
  logic        echo_prev_q, echo_prev_d;

  logic        wr_s, start_s, auto_fire_s, busy_s;
  logic        rise_s, fall_s;
  logic        tick_s, tick_clr_s, auto_tick_s, auto_clr_s;
  logic [1:0]  sel_s;
  logic        unused_s;

  assign sel_s   = bus.daddr[3:2];
  assign wr_s    = bus.de && (bus.drw == DRW_WRITE);
  assign start_s = wr_s && (sel_s == REG_CTRL) && bus.din[CTRL_START];
  assign busy_s  = (state_q != ST_IDLE);
  assign rise_s  = echo_sync_q & ~echo_prev_q;
  assign fall_s  = ~echo_sync_q & echo_prev_q;

  // Measurement ticks restart on every state change so each phase starts
  // on a full tick boundary.
  assign tick_clr_s = (state_d != state_q);
  // The auto-repeat timebase runs freely while auto is on, so the repeat
  // interval is not disturbed by the measurement divider restarts.
  assign auto_clr_s = ~auto_q;

  assign unused_s = ^{bus.ie, bus.iaddr, bus.daddr[31:4], bus.daddr[1:0],
                      bus.din[31:24], bus.drw};

  sonar_tick #(.DIV(TICK_DIV)) u_meas_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (tick_clr_s),
    .tick_en (tick_s)
  );

  sonar_tick #(.DIV(TICK_DIV)) u_auto_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (auto_clr_s),
    .tick_en (auto_tick_s)
  );

  // Register writes, auto-repeat counter, measurement FSM and echo sync
  always_comb begin
    state_d     = state_q;
    cnt_run_s   = cnt_q;
    width_d     = width_q;
    result_d    = result_q;
    valid_d     = valid_q;
    timeout_d   = timeout_q;
    auto_d      = auto_q;
    irq_en_d    = irq_en_q;
    period_d    = period_q;
    per_cnt_d   = per_cnt_q;
    auto_fire_s = 1'b0;
    width_inc_s = tick_s ? sat_inc16(width_q) : width_q;

    if (wr_s && (sel_s == REG_CTRL)) begin
      auto_d   = bus.din[CTRL_AUTO];
      irq_en_d = bus.din[CTRL_IRQ_EN];
    end else if (wr_s && (sel_s == REG_PERIOD)) begin
      period_d = bus.din[23:0];
    end else begin
      period_d = period_q;
    end

    // Auto fire: PERIOD=0 means fire whenever idle; otherwise fire on the
    // tick that completes PERIOD ticks. Fires while busy are simply lost.
    if (!auto_q) begin
      per_cnt_d = 24'd0;
    end else if (period_q == 24'd0) begin
      auto_fire_s = 1'b1;
      per_cnt_d   = 24'd0;
    end else if (auto_tick_s && ((per_cnt_q + 24'd1) >= period_q)) begin
      auto_fire_s = 1'b1;
      per_cnt_d   = 24'd0;
    end else if (auto_tick_s) begin
      per_cnt_d = per_cnt_q + 24'd1;
    end else begin
      per_cnt_d = per_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s || auto_fire_s) begin
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_TRIG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
        end else begin
          cnt_run_s = cnt_q + 16'd1;
        end
      end
      ST_WAIT_RISE: begin
        if (rise_s) begin
          width_d = 16'd0;
          state_d = ST_MEASURE;
        end else if (tick_s && (cnt_q == TO_LAST)) begin
          result_d  = TIMEOUT_CODE;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (tick_s) begin
          cnt_run_s = cnt_q + 16'd1;
        end else begin
          cnt_run_s = cnt_q;
        end
      end
      ST_MEASURE: begin
        width_d = width_inc_s;
        // A tick landing on the falling-edge cycle still counts.
        if (fall_s) begin
          result_d = width_inc_s;
          state_d  = ST_DONE;
        end else if (tick_s && (cnt_q == TO_LAST)) begin
          result_d  = TIMEOUT_CODE;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else if (tick_s) begin
          cnt_run_s = cnt_q + 16'd1;
        end else begin
          cnt_run_s = cnt_q;
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The phase counter restarts on every state entry.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_run_s;
    end

    trig_d = (state_d == ST_TRIG);
    irq_d  = (state_d == ST_DONE) && irq_en_q;

    echo_meta_d = sonar_echo;
    echo_sync_d = echo_meta_q;
    echo_prev_d = echo_sync_q;
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      width_q     <= 16'd0;
      result_q    <= 16'd0;
      period_q    <= 24'd0;
      per_cnt_q   <= 24'd0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      trig_q      <= 1'b0;
      irq_q       <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      result_q    <= result_d;
      period_q    <= period_d;
      per_cnt_q   <= per_cnt_d;
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      trig_q      <= trig_d;
      irq_q       <= irq_d;
      echo_meta_q <= echo_meta_d;
      echo_sync_q <= echo_sync_d;
      echo_prev_q <= echo_prev_d;
    end
  end

  assign sonar_trig = trig_q;
  assign i_sonar    = irq_q;
  assign bus.iout   = 32'd0;

  // Read mux: combinational, side-effect free, zero when not selected
  always_comb begin
    bus.dout = 32'd0;
    if (bus.de) begin
      case (sel_s)
        REG_CTRL:   bus.dout = {27'd0, timeout_q, valid_q, irq_en_q, auto_q, busy_s};
        REG_RESULT: bus.dout = {16'd0, result_q};
        REG_PERIOD: bus.dout = {8'd0, period_q};
        default:    bus.dout = 32'd0;
      endcase
    end else begin
      bus.dout = 32'd0;
    end
  end

endmodule

// File: tb/tb_mod_sonar.sv
module tb_mod_sonar;
  import sonar_pkg::*;

  localparam int TRIG = 20;
  localparam int D    = 4;
  localparam int TO   = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sonar_echo = 1'b0;
  logic sonar_trig;
  logic i_sonar;

  mod_sonar_if bus_if ();

  mod_sonar #(.TRIG_CYCLES(TRIG), .TICK_DIV(D), .TIMEOUT_TICKS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .sonar_trig (sonar_trig),
    .sonar_echo (sonar_echo),
    .i_sonar    (i_sonar)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig_rises = 0;
  int irq_cycles = 0;
  int cur_len = 0;
  int last_trig_len = 0;
  int rise_cyc[$];
  logic prev_trig = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = (obs > exp) ? (obs - exp) : (exp - obs);
    checks++;
    assert (diff <= tol) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // One clock, then observe trigger / interrupt activity.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sonar_trig && !prev_trig) begin
      trig_rises++;
      rise_cyc.push_back(cyc);
      cur_len = 0;
    end
    if (sonar_trig) cur_len++;
    if (!sonar_trig && prev_trig) last_trig_len = cur_len;
    if (i_sonar === 1'b1) irq_cycles++;
    prev_trig = sonar_trig;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    bus_if.de    = 1'b1;
    bus_if.drw   = 2'b01;
    bus_if.daddr = {28'd0, idx, 2'b00};
    bus_if.din   = data;
    step();
    bus_if.de    = 1'b0;
    bus_if.drw   = 2'b00;
    bus_if.din   = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
    bus_if.de    = 1'b1;
    bus_if.drw   = 2'b10;
    bus_if.daddr = {28'd0, idx, 2'b00};
    #1;
    data = bus_if.dout;
    bus_if.de  = 1'b0;
    bus_if.drw = 2'b00;
  endtask

  task automatic wait_trig(input logic level, input int max, input string tag);
    int n;
    n = 0;
    while (sonar_trig !== level && n < max) begin
      step();
      n++;
    end
    check(tag, {31'd0, sonar_trig}, {31'd0, level});
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    logic [31:0] r;
    n = 0;
    bus_read(REG_CTRL, r);
    while (r[0] && n < max) begin
      step();
      bus_read(REG_CTRL, r);
      n++;
    end
    check(tag, {31'd0, r[0]}, 32'd0);
  endtask

  task automatic echo_pulse(input int delay_ticks, input int width_ticks);
    hold(delay_ticks * D);
    sonar_echo = 1'b1;
    hold(width_ticks * D);
    sonar_echo = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int r0, irq0, n0;

    bus_if.ie    = 1'b0;
    bus_if.de    = 1'b0;
    bus_if.iaddr = 32'h0000_1234;
    bus_if.daddr = 32'd0;
    bus_if.drw   = 2'b00;
    bus_if.din   = 32'd0;

    // Reset state
    hold(2);
    check("rst_trig", {31'd0, sonar_trig}, 32'd0);
    check("rst_irq", {31'd0, i_sonar}, 32'd0);
    bus_read(REG_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    bus_read(REG_RESULT, rd); check("rst_result", rd, 32'd0);
    bus_read(REG_PERIOD, rd); check("rst_period", rd, 32'd0);
    check("rst_iout", bus_if.iout, 32'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of the trigger pulse
    bus_write(REG_CTRL, 32'h1);
    hold(5);
    check("midtrig_trig_on", {31'd0, sonar_trig}, 32'd1);
    rst = 1'b1;
    step();
    check("midrst_trig", {31'd0, sonar_trig}, 32'd0);
    step();
    bus_read(REG_CTRL, rd); check("midrst_ctrl", rd, 32'd0);
    check("midrst_irq", {31'd0, i_sonar}, 32'd0);
    rst = 1'b0;
    step();

    // Basic measurement: echo 150 ticks wide, irq enabled
    r0 = trig_rises; irq0 = irq_cycles;
    bus_write(REG_CTRL, 32'h5);
    wait_trig(1'b0, TRIG + 10, "basic_trig_fall");
    check("basic_trig_len", last_trig_len, TRIG);
    echo_pulse(20, 150);
    wait_idle(50, "basic_done");
    hold(2);
    bus_read(REG_RESULT, rd); check_near("basic_result", int'(rd), 150, 1);
    bus_read(REG_CTRL, rd);   check("basic_ctrl", rd, 32'h0C);
    check("basic_irq_cycles", irq_cycles - irq0, 32'd1);
    check("basic_trig_count", trig_rises - r0, 32'd1);

    // No echo: timeout, irq disabled
    irq0 = irq_cycles;
    bus_write(REG_CTRL, 32'h1);
    wait_idle(TRIG + TO * D + 100, "noecho_done");
    bus_read(REG_RESULT, rd); check("noecho_result", rd, 32'h0000_FFFF);
    bus_read(REG_CTRL, rd);   check("noecho_ctrl", rd, 32'h18);
    check("noecho_irq", irq_cycles - irq0, 32'd0);

    // Bus decode
    bus_if.de = 1'b0; bus_if.drw = 2'b10; bus_if.daddr = 32'd0;
    #1;
    check("de0_dout", bus_if.dout, 32'd0);
    bus_if.drw = 2'b00;
    r0 = trig_rises;
    bus_write(REG_RESULT, 32'h0000_1235);
    bus_read(REG_RESULT, rd); check("ro_result", rd, 32'h0000_FFFF);
    bus_write(REG_RSVD, 32'hFFFF_FFFF);
    bus_read(REG_RSVD, rd);   check("rsvd_read", rd, 32'd0);
    bus_read(REG_CTRL, rd);   check("rsvd_ctrl", rd, 32'h18);
    step();
    check("decode_no_trig", trig_rises - r0, 32'd0);
    bus_write(REG_PERIOD, 32'hFFFF_FFFF);
    bus_read(REG_PERIOD, rd); check("period_24b", rd, 32'h00FF_FFFF);
    check("iout_zero", bus_if.iout, 32'd0);

    // Busy collision: second start during MEASURE is ignored
    r0 = trig_rises; irq0 = irq_cycles;
    bus_write(REG_CTRL, 32'h5);
    wait_trig(1'b0, TRIG + 10, "coll_trig_fall");
    hold(10 * D);
    sonar_echo = 1'b1;
    hold(20 * D);
    bus_write(REG_CTRL, 32'h5);
    hold(40 * D - 1);
    sonar_echo = 1'b0;
    wait_idle(50, "coll_done");
    hold(TRIG + 10);
    check("coll_trig_count", trig_rises - r0, 32'd1);
    bus_read(REG_RESULT, rd); check_near("coll_result", int'(rd), 60, 1);
    check("coll_irq_cycles", irq_cycles - irq0, 32'd1);

    // Auto mode: PERIOD=500 ticks, echo 100 ticks, irq disabled
    irq0 = irq_cycles;
    bus_write(REG_PERIOD, 32'd500);
    bus_write(REG_CTRL, 32'h2);
    n0 = rise_cyc.size();
    for (int k = 0; k < 3; k++) begin
      wait_trig(1'b1, 500 * D + 100, "auto_rise");
      wait_trig(1'b0, TRIG + 10, "auto_fall");
      echo_pulse(20, 100);
    end
    bus_write(REG_CTRL, 32'h0);
    wait_idle(50, "auto_done");
    check("auto_rise_count", rise_cyc.size() - n0, 32'd3);
    if (rise_cyc.size() >= n0 + 3) begin
      check_near("auto_spacing1", rise_cyc[n0 + 1] - rise_cyc[n0], 500 * D, D);
      check_near("auto_spacing2", rise_cyc[n0 + 2] - rise_cyc[n0 + 1], 500 * D, D);
    end
    bus_read(REG_RESULT, rd); check_near("auto_result", int'(rd), 100, 1);
    check("auto_irq", irq_cycles - irq0, 32'd0);
    bus_read(REG_PERIOD, rd); check("auto_period", rd, 32'd500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
